// File: rtl/tri_pixel_buffer_if.sv
// Renderer-side pixel stream plus row-drain handshake for tri_pixel_buffer.
// The pix_cnt signal exists only when TRI_PIX_COUNT_EN is defined.
interface tri_pixel_buffer_if;
  // Renderer pixel stream
  logic       rend_busy;
  logic       pix_v;
  logic [2:0] pix_x;
  logic [2:0] pix_y;

  // Controller status and row drain
  logic       tri_ready;
  logic       row_valid;
  logic [2:0] row_idx;
  logic [7:0] row_data;
  logic       rd_ready;
  logic       frame_done;
  logic       overrun;
`ifdef TRI_PIX_COUNT_EN
  logic [6:0] pix_cnt;
`endif

  modport master (
    output rend_busy, pix_v, pix_x, pix_y, rd_ready,
    input  tri_ready, row_valid, row_idx, row_data, frame_done, overrun
`ifdef TRI_PIX_COUNT_EN
    , input pix_cnt
`endif
  );

  modport slave (
    input  rend_busy, pix_v, pix_x, pix_y, rd_ready,
    output tri_ready, row_valid, row_idx, row_data, frame_done, overrun
`ifdef TRI_PIX_COUNT_EN
    , output pix_cnt
`endif
  );
endinterface

// File: rtl/tri_pixel_buffer.sv
// Captures the renderer's pixel stream into an 8x8 bitmap, then drains it row by row.
// Define TRI_PIX_COUNT_EN to add the distinct-pixel counter (pix_cnt).
module tri_pixel_buffer (
  input  logic              clk,
  input  logic              reset,
  tri_pixel_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DUMP    = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0][7:0] bm_q, bm_d;      // bm_q[y][x]
  logic [2:0]      row_q, row_d;
  logic            overrun_q, overrun_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (bus.rend_busy) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!bus.rend_busy) begin
          state_d = DUMP;
          row_d   = 3'd0;
        end
      end
      DUMP: begin
        if (bus.rd_ready) begin
          if (row_q == 3'd7) state_d = DONE;
          row_d = row_q + 3'd1;     // wraps to 0 after row 7
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixels are taken only in CAPTURE, including the cycle in which busy falls.
  always_comb begin
    bm_d = bm_q;
    if (state_q == DONE) begin
      bm_d = '0;
    end else if (state_q == CAPTURE && bus.pix_v) begin
      bm_d[bus.pix_y][bus.pix_x] = 1'b1;
    end
  end

  // A new triangle started before the drain finished is flagged, never recovered.
  always_comb begin
    overrun_d = overrun_q;
    if ((state_q == DUMP || state_q == DONE) && bus.rend_busy) overrun_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments in clocked blocks, so all registers update together.
  // NOTE: the bitmap is real flops, not a RAM, so clearing it on reset is free and required.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bm_q      <= '0;
      row_q     <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bm_q      <= bm_d;
      row_q     <= row_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef TRI_PIX_COUNT_EN
  logic [6:0] pix_cnt_q, pix_cnt_d;

  // Counts only bits that go 0->1, so duplicate coordinates are not counted.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (state_q == IDLE && bus.rend_busy) begin
      pix_cnt_d = 7'd0;
    end else if (state_q == CAPTURE && bus.pix_v && !bm_q[bus.pix_y][bus.pix_x]) begin
      pix_cnt_d = pix_cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pix_cnt_q <= 7'd0;
    else       pix_cnt_q <= pix_cnt_d;
  end

  assign bus.pix_cnt = pix_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // ---------------------------------------------------------------------------
  assign bus.tri_ready  = (state_q == IDLE);
  assign bus.row_valid  = (state_q == DUMP);
  assign bus.row_idx    = row_q;
  assign bus.row_data   = (state_q == DUMP) ? bm_q[row_q] : 8'h00;
  assign bus.frame_done = (state_q == DONE);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_tri_pixel_buffer.sv
// Directed bench for tri_pixel_buffer: capture, row drain with stalls, overrun and reset.
module tb_tri_pixel_buffer;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  tri_pixel_buffer_if bus ();

  tri_pixel_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [2:0] x, input logic [2:0] y);
    bus.pix_v = 1'b1;
    bus.pix_x = x;
    bus.pix_y = y;
    tick();
    bus.pix_v = 1'b0;
  endtask

  task automatic start_frame();
    bus.rend_busy = 1'b1;
    tick();
    check("tri_ready_in_capture", 8'(bus.tri_ready), 8'd0);
  endtask

  task automatic check_row(input int r, input logic [7:0] d);
    check($sformatf("row_valid[%0d]", r), 8'(bus.row_valid), 8'd1);
    check($sformatf("row_idx[%0d]", r), 8'(bus.row_idx), 8'(r));
    check($sformatf("row_data[%0d]", r), bus.row_data, d);
  endtask

  // Expects DUMP to be presenting row 0; drains all rows, optionally stalling one.
  task automatic drain(input logic [63:0] exp, input int stall_row, input int stall_cycles);
    for (int r = 0; r < 8; r++) begin
      if (r == stall_row) begin
        bus.rd_ready = 1'b0;
        for (int c = 0; c < stall_cycles; c++) begin
          check_row(r, exp[8*r +: 8]);
          tick();
        end
        bus.rd_ready = 1'b1;
      end
      check_row(r, exp[8*r +: 8]);
      tick();
    end
    check("frame_done_pulse", 8'(bus.frame_done), 8'd1);
    check("row_valid_in_done", 8'(bus.row_valid), 8'd0);
    check("tri_ready_in_done", 8'(bus.tri_ready), 8'd0);
    tick();
    check("frame_done_clear", 8'(bus.frame_done), 8'd0);
    check("tri_ready_after_done", 8'(bus.tri_ready), 8'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tri_ready"}, 8'(bus.tri_ready), 8'd1);
    check({tag, "_row_valid"}, 8'(bus.row_valid), 8'd0);
    check({tag, "_row_idx"}, 8'(bus.row_idx), 8'd0);
    check({tag, "_row_data"}, bus.row_data, 8'h00);
    check({tag, "_frame_done"}, 8'(bus.frame_done), 8'd0);
    check({tag, "_overrun"}, 8'(bus.overrun), 8'd0);
`ifdef TRI_PIX_COUNT_EN
    check({tag, "_pix_cnt"}, 8'(bus.pix_cnt), 8'd0);
`endif
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.rend_busy = 1'b0;
    bus.pix_v     = 1'b0;
    bus.pix_x     = 3'd0;
    bus.pix_y     = 3'd0;
    bus.rd_ready  = 1'b1;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Pixels in IDLE must be ignored (they would show as row0=0x21, row3=0x08)
    pixel(3'd3, 3'd3);
    pixel(3'd5, 3'd0);
    check("tri_ready_idle", 8'(bus.tri_ready), 8'd1);

    // Frame 1: (0,0) (0,1) (1,1) -> row0=0x01, row1=0x03
    start_frame();
    pixel(3'd0, 3'd0);
    pixel(3'd0, 3'd1);
    pixel(3'd1, 3'd1);
    bus.rend_busy = 1'b0;
    tick();
`ifdef TRI_PIX_COUNT_EN
    check("pix_cnt_frame1", 8'(bus.pix_cnt), 8'd3);
`endif
    drain(64'h0000_0000_0000_0301, -1, 0);

    // Frame 2 back-to-back: (4,3), plus (7,7) in the cycle busy falls; stall row 3
    start_frame();
    pixel(3'd4, 3'd3);
    bus.pix_v     = 1'b1;
    bus.pix_x     = 3'd7;
    bus.pix_y     = 3'd7;
    bus.rend_busy = 1'b0;
    tick();
    bus.pix_v     = 1'b0;
    drain(64'h8000_0000_1000_0000, 3, 3);

    // Frame 3: (2,2) twice plus (3,2) -> row2=0x0C, two distinct pixels
    start_frame();
    pixel(3'd2, 3'd2);
    pixel(3'd2, 3'd2);
    pixel(3'd3, 3'd2);
    bus.rend_busy = 1'b0;
    tick();
`ifdef TRI_PIX_COUNT_EN
    check("pix_cnt_dup", 8'(bus.pix_cnt), 8'd2);
`endif
    drain(64'h0000_0000_000C_0000, -1, 0);
    check("overrun_clean", 8'(bus.overrun), 8'd0);

    // Frame 4: busy during DUMP sets overrun; a pixel (6,6) then is dropped
    start_frame();
    pixel(3'd1, 3'd0);
    bus.rend_busy = 1'b0;
    tick();
    check_row(0, 8'h02);
    bus.rend_busy = 1'b1;
    bus.pix_v     = 1'b1;
    bus.pix_x     = 3'd6;
    bus.pix_y     = 3'd6;
    tick();
    bus.rend_busy = 1'b0;
    bus.pix_v     = 1'b0;
    check("overrun_set", 8'(bus.overrun), 8'd1);
    check_row(1, 8'h00);
    for (int r = 2; r < 7; r++) begin
      tick();
      check_row(r, 8'h00);
    end
    check("overrun_sticky", 8'(bus.overrun), 8'd1);

    // Asynchronous reset mid-DUMP takes effect without a clock edge
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_dump_reset");
    tick();
    reset = 1'b0;
    tick();

    // Frame 5: only (5,5); row0 from the aborted frame must be gone
    start_frame();
    pixel(3'd5, 3'd5);
    bus.rend_busy = 1'b0;
    tick();
    drain(64'h0000_2000_0000_0000, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
